// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FIFO with occupancy count, thresholds, flush and optional output register
module stream_fifo #(
  parameter int DATAW     = 64,
  parameter int DEPTH     = 128,
  parameter int OUT_REG   = 0,
  parameter int AF_THRESH = DEPTH,
  parameter int AE_THRESH = 0,
  localparam int CAP      = DEPTH + OUT_REG,
  localparam int CNTW     = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTRW-1:0] LAST = PTRW'(DEPTH - 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic             push;
  logic             pop;
  logic             arr_pop;

  // Explicit wrap so non-power-of-two depths use every entry.
  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == LAST) ? '0 : p + PTRW'(1);
  endfunction

  assign in_ready = !rst && !flush && (int'(count) < CAP);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tail <= '0;
      head <= '0;
    end else begin
      if (push) begin
        tail <= next_ptr(tail);
      end
      if (arr_pop) begin
        head <= next_ptr(head);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNTW'(1);
    end else if (pop && !push) begin
      count <= count - CNTW'(1);
    end
  end

  generate
    if (OUT_REG == 0) begin : g_fwft
      assign arr_pop   = pop;
      assign out_valid = (count != '0);
      assign out_data  = mem[head];
    end else begin : g_oreg
      logic [DATAW-1:0] oreg;
      logic             oreg_v;
      logic             arr_empty;

      // count includes the output register, so the array holds count - oreg_v.
      assign arr_empty = (count == CNTW'(oreg_v));
      assign arr_pop   = !rst && !flush && !arr_empty && (!oreg_v || pop);
      assign out_valid = oreg_v;
      assign out_data  = oreg;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          oreg_v <= 1'b0;
        end else if (arr_pop) begin
          oreg_v <= 1'b1;
        end else if (pop) begin
          oreg_v <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (arr_pop) begin
          oreg <= mem[head];
        end
      end
    end
  endgenerate

  assign almost_full  = (int'(count) >= AF_THRESH);
  assign almost_empty = (int'(count) <= AE_THRESH);

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised valid/ready FIFO that succeeds the push/pop peek FIFO in the MLP controller. It uses all DEPTH entries, supports non-power-of-two depths, and reports an occupancy count. It has programmable almost-full/almost-empty thresholds, a synchronous flush, and an optional registered output stage for timing closure. It sits between the instruction/weight fetch paths and the MLP compute controller, wherever a buffered elastic stream is needed.

## Interface
- DATAW, 64, data word width (>=1)
- DEPTH, 128, storage entries in the array (>=2, any integer)
- OUT_REG, 0, 0 = first-word-fall-through from the array; 1 = extra registered output entry
- AF_THRESH, DEPTH, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 0, almost_empty asserts when count <= AE_THRESH
- CAP (derived), DEPTH+OUT_REG, total capacity
- CNTW (derived), $clog2(CAP+1), count width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of all contents
- in_valid  in  1  producer has a word
- in_data  in  DATAW  write data
- in_ready  out  1  FIFO accepts a word this cycle
- out_valid  out  1  out_data holds the head word
- out_data  out  DATAW  head word (peek)
- out_ready  in  1  consumer takes the head word this cycle
- count  out  CNTW  entries held, including the output register
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH

## Operation
- Clock is clk. Reset is rst, synchronous and active-high.
- Push is in_valid && in_ready. Pop is out_valid && out_ready. Both are evaluated on the same edge.
- in_ready = !rst && !flush && (count < CAP). There is no pass-through when full: a pop at full does not enable a same-cycle push.
- Head and tail pointers wrap explicitly: DEPTH-1 -> 0, with no reliance on power-of-two overflow.
- OUT_REG=0:
  - out_valid = (count != 0).
  - out_data = mem[head], read combinationally.
- OUT_REG=1:
  - Output register (oreg, oreg_v) is loaded from the array whenever it is empty or being popped and the array is non-empty.
  - out_valid = oreg_v and out_data = oreg.
  - Array words never bypass oreg.
- count is updated each cycle by: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds CAP and never underflows.
- almost_full and almost_empty are decoded from the registered count and have no combinational path from the inputs.
- flush takes priority over push and pop:
  - The next cycle has count=0, both pointers at 0, out_valid=0, and oreg_v=0.
  - A push or pop presented in the flush cycle is discarded.
- Storage contents are not cleared by rst or flush. Only pointers, count and valid flags are cleared.
- Out-of-handshake input is ignored: in_valid while !in_ready, or out_ready while !out_valid, has no effect.

## Timing
- Reset values, in the cycle after rst is sampled high:
  - count=0, out_valid=0, almost_full=(AF_THRESH==0), almost_empty=1.
  - in_ready=0 while rst is high, and 1 in the first cycle after it is released.
  - out_data is undefined (don't-care) while out_valid=0.
- Reset mid-operation: all contents are lost on the reset edge. No partial pop or push completes.
- Latency, empty FIFO:
  - OUT_REG=0: push at edge t gives out_valid=1 after edge t, with the same data.
  - OUT_REG=1: push at edge t gives out_valid=1 after edge t+1.
- Throughput is one push and one pop per cycle sustained at any fill level between 0 and CAP, excluding the empty-with-OUT_REG=1 bubble.
- Simultaneous cases:
  - Push+pop at count=0: the pop is ignored (out_valid=0) and count becomes 1.
  - Push+pop at 0<count<CAP: count is unchanged and ordering is preserved.
  - At count=CAP: only the pop takes effect and count becomes CAP-1.
- Status flags lag count changes by zero cycles, since both are registered together.

## Test plan
- Fill/drain, DEPTH=4, OUT_REG=0:
  - Push 0x11,0x22,0x33,0x44 on consecutive cycles. in_ready drops after the 4th edge and count=4.
  - A 5th in_valid is ignored.
  - Draining yields 0x11..0x44 in order, and count=0 after the 4th pop.
- Non-power-of-two wrap, DEPTH=5:
  - Push/pop 13 words with random stalls and verify order.
  - Pointers pass index 4 -> 0 at least twice. count never exceeds 5.
- OUT_REG=1, DEPTH=4:
  - Single push into empty gives out_valid exactly 2 edges later.
  - Capacity is 5: the 6th in_valid is refused.
  - With continuous push+pop at steady state, count holds constant.
- Thresholds, AF_THRESH=3, AE_THRESH=1:
  - almost_empty=1 at count 0..1.
  - almost_full=1 exactly when count>=3, toggling on the edges where count crosses.
- Flush with simultaneous push+pop at count=3:
  - The next cycle has count=0, out_valid=0, and in_ready=1.
  - A subsequent push of 0xAB produces out_data=0xAB. No stale data appears.
- Reset mid-stream at count=2:
  - in_ready=0 during rst.
  - After release, count=0 and out_valid=0, and the first popped word is the first word pushed after reset.
